mips_multicycle_control: RTL
============================

Name: mips_multicycle_control

Overview:
Multicycle MIPS control unit: Moore FSM that decodes the instruction opcode and sequences the datapath. It sits directly upstream of the datapath muxes and drives their selects: reg_dst for the 5-bit write-register mux, and mem_to_reg / alu_src_a for the 32-bit muxes. It also drives register-file, memory, IR and PC enables. Memory accesses use a ready handshake so variable-latency memory stalls the FSM.

Parameters:
STATE_W, 4, width of the state register and the debug state output.
TRAP_STICKY, 1, 1 = TRAP holds until reset; 0 = TRAP returns to FETCH after one cycle.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous and active-low
opcode  in  6  instr[31:26], taken from the IR
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if the branch condition is true
iord  out  1  0 = address is PC, 1 = address is ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
mem_to_reg  out  1  write-data mux select: 1 = MDR, 0 = ALUOut
reg_dst  out  1  write-register mux select: 1 = rd, 0 = rt
reg_write  out  1  register-file write enable
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
branch_ne  out  1  inverts the branch condition (tied 0 without the option)
illegal_op  out  1  high while in TRAP
state  out  STATE_W  current state (debug)

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, TRAP=12. Codes 13-15 are unreachable and go to FETCH.
- Outputs are a pure decode of the state register plus mem_ready (Moore-style). No output depends on opcode directly.
- Reset: state=FETCH asynchronously. While rst_n=0, all enables (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write) are forced to 0. All selects are 0 and illegal_op=0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write=pc_write=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - 100011 / 101011 → MEMADR
  - 000000 → EXEC
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDIEX
  - anything else → TRAP
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, iord=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEMWR: mem_write=1, iord=1. Waits for mem_ready, then goes to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10. Goes to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- TRAP: illegal_op=1 and all enables 0. Holds if TRAP_STICKY=1; otherwise goes to FETCH next cycle.
- Memory requests (mem_read / mem_write) stay asserted and stable for the whole wait. mem_ready is ignored in states that make no memory request.
- Reset asserted mid-wait aborts the access immediately; no write enable may glitch high.
- Latency with zero-wait memory: lw=5 cycles, sw=4, R-type=4, addi=4, beq=3, j=3.

Optional Feature:
CTRL_BNE_EN.
- Defined: opcode 000101 goes from DECODE to BRANCH, and branch_ne=1 in BRANCH for that instruction. The opcode is captured in a 1-bit flag in DECODE.
- Undefined: 000101 goes to TRAP and branch_ne is constant 0.

Decomposition:
- Shared package mips_ctrl_pkg holds the state encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI), alu_op codes, alu_src_b codes and pc_source codes.
- One sub-module, mips_ctrl_decode: combinational state + mem_ready → control word. The top holds the state register and next-state logic.

Test Plan:
- Reset pulse mid-MEMWR (rst_n low for 1 cycle) → state=0 at once; mem_write, reg_write, pc_write all 0 during and after reset.
- lw (100011), mem_ready always 1 → states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 and reg_dst=0 only in state 4.
- R-type (000000), mem_ready held low 3 cycles in FETCH → FETCH holds 4 cycles with mem_read=1 and ir_write=0 until ready; then 1,6,7 with reg_dst=1 in state 7.
- sw (101011), mem_ready low 2 cycles in MEMWR → mem_write=1 and iord=1 stable for 3 cycles, then FETCH; reg_write never asserted.
- beq (000100) → 0,1,8,0 with alu_op=01, pc_source=01, pc_write_cond=1 in state 8. j (000010) → pc_write=1, pc_source=10 in state 9.
- Opcode 111111 → TRAP, illegal_op=1 held for 10 cycles (TRAP_STICKY=1). Opcode 000101 → TRAP without CTRL_BNE_EN; with it, BRANCH and branch_ne=1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Purpose : shared encodings for the multicycle MIPS control unit (states, opcodes,
//           mux select codes) plus the control-word struct and the DECODE dispatch.
// Latency : n/a (types, constants and one pure function).
// Backpressure: n/a.
package mips_ctrl_pkg;

  localparam int ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // alu_op codes
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // alu_src_b codes
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // pc_source codes
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  // Successor of DECODE for a given opcode. bne_en selects whether bne is a
  // legal branch or falls through to TRAP like any unknown opcode.
  function automatic state_t dispatch(input logic [5:0] op, input logic bne_en);
    state_t nxt;
    case (op)
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_RTYPE:     nxt = S_EXEC;
      OP_BEQ:       nxt = S_BRANCH;
      OP_BNE:       nxt = bne_en ? S_BRANCH : S_TRAP;
      OP_J:         nxt = S_JUMP;
      OP_ADDI:      nxt = S_ADDIEX;
      default:      nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Purpose : combinational decode of the FSM state (plus mem_ready) into the control word.
// Latency : 0 cycles, pure combinational.
// Backpressure: mem_ready only gates ir_write/pc_write in FETCH; memory requests are
//               held by the state itself while waiting.
// Ports   : state (current FSM state), mem_ready (memory handshake), ctrl (control word).
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        // PC+4 is computed during the fetch; IR and PC commit on the ready cycle
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target: PC + (imm << 2)
        ctrl.alu_src_b = SRCB_IMM_SH2;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_TRAP: begin
        ctrl.illegal_op = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Purpose : multicycle MIPS control FSM; sequences datapath enables and mux selects.
// Latency : zero-wait memory: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3 cycles.
// Backpressure: FETCH/MEMRD/MEMWR hold with the request asserted until mem_ready.
// Ports   : clk, rst_n (async active-low), opcode (IR[31:26]), mem_ready;
//           datapath enables/selects, branch_ne, illegal_op, state (debug).
// Option  : define CTRL_BNE_EN to decode bne (000101) as a branch with branch_ne=1.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W     = 4,
  parameter bit TRAP_STICKY = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               branch_ne,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

`ifdef CTRL_BNE_EN
  localparam logic BNE_EN = 1'b1;
`else
  localparam logic BNE_EN = 1'b0;
`endif

  state_t cur;
  ctrl_t  ctrl_raw;
  ctrl_t  ctrl_out;

  // opcode is stable from DECODE until the next FETCH completes, so MEMADR
  // may still look at it to split lw from sw.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH:  if (mem_ready) cur <= S_DECODE;
        S_DECODE: cur <= dispatch(opcode, BNE_EN);
        S_MEMADR: cur <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) cur <= S_MEMWB;
        S_MEMWR:  if (mem_ready) cur <= S_FETCH;
        S_EXEC:   cur <= S_ALUWB;
        S_ADDIEX: cur <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: cur <= S_FETCH;
        S_TRAP:   if (!TRAP_STICKY) cur <= S_FETCH;
        default:  cur <= S_FETCH;
      endcase
    end
  end

  mips_ctrl_decode u_decode (
    .state     (cur),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_raw)
  );

  // Gate with rst_n directly so an asynchronous reset mid-access drops every
  // request and enable in the same instant, not at the next edge.
  assign ctrl_out = rst_n ? ctrl_raw : '0;

  assign pc_write      = ctrl_out.pc_write;
  assign pc_write_cond = ctrl_out.pc_write_cond;
  assign iord          = ctrl_out.iord;
  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign ir_write      = ctrl_out.ir_write;
  assign mem_to_reg    = ctrl_out.mem_to_reg;
  assign reg_dst       = ctrl_out.reg_dst;
  assign reg_write     = ctrl_out.reg_write;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign alu_op        = ctrl_out.alu_op;
  assign pc_source     = ctrl_out.pc_source;
  assign illegal_op    = ctrl_out.illegal_op;
  assign state         = STATE_W'(cur);

`ifdef CTRL_BNE_EN
  // Remembers whether the branch in flight is bne; sampled once in DECODE.
  logic bne_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bne_flag <= 1'b0;
    end else if (cur == S_DECODE) begin
      bne_flag <= (opcode == OP_BNE);
    end
  end

  assign branch_ne = rst_n & (cur == S_BRANCH) & bne_flag;
`else
  assign branch_ne = 1'b0;
`endif

endmodule
